// File: rtl/pico2_port_pkg.sv
// pico2_port_pkg
//   Shared constants for the pico2 port responder: the core-side port map
//   and the bit positions of the status byte returned on the status port.
//   Also provides a helper that assembles the status byte.
package pico2_port_pkg;

    // Core port map
    localparam logic [7:0] PORT_KEY_ADDR = 8'h20;  // W: key memory address
    localparam logic [7:0] PORT_KEY_DATA = 8'h21;  // R: key memory data
    localparam logic [7:0] PORT_FIFO_POP = 8'h22;  // R: pop byte FIFO
    localparam logic [7:0] PORT_STATUS   = 8'h23;  // R: status, W: clear sticky flags
    localparam logic [7:0] PORT_RES_ADDR = 8'h40;  // W: result memory address
    localparam logic [7:0] PORT_RES_DATA = 8'h41;  // W: result memory data

    // Status byte bit indices; upper nibble reads as zero
    localparam int STAT_EMPTY     = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_UNDERFLOW = 3;

    function automatic logic [7:0] pack_status(input logic empty,
                                               input logic full,
                                               input logic overflow,
                                               input logic underflow);
        logic [7:0] s;
        s                 = 8'h00;
        s[STAT_EMPTY]     = empty;
        s[STAT_FULL]      = full;
        s[STAT_OVERFLOW]  = overflow;
        s[STAT_UNDERFLOW] = underflow;
        return s;
    endfunction

endpackage

// File: rtl/pico2_port_responder_if.sv
// pico2_port_responder_if
//   Soft-core I/O port bus.
//   port_id      : port address driven by the core
//   write_strobe : one-cycle write qualifier
//   read_strobe  : one-cycle read qualifier
//   out_port     : core write data
//   in_port      : registered read data returned to the core
//   master = core side, slave = peripheral side.
interface pico2_port_responder_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;

    modport master (
        output port_id, write_strobe, read_strobe, out_port,
        input  in_port
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port,
        output in_port
    );
endinterface

// File: rtl/pico2_byte_fifo.sv
// pico2_byte_fifo
//   Byte FIFO with occupancy count.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push/push_data: enqueue request (ignored when full)
//   pop          : dequeue request (ignored when empty)
//   head_data    : byte at the read pointer (valid when !empty)
//   full, empty  : combinational from the count
//   DEPTH must be a power of two >= 4 so pointers wrap naturally.
module pico2_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head_data,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign push_ok   = push && !full;
    assign pop_ok    = pop && !empty;
    assign head_data = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, pop_ok};
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/pico2_port_responder.sv
// pico2_port_responder
//   Port-mapped peripheral for a soft core: key memory readback, byte FIFO
//   pop with sticky overflow/underflow status, and a result memory the core
//   writes and the host reads.
//   clk, rst_n          : clock, asynchronous active-low reset
//   core                : core port bus (slave side)
//   fifo_push/_data     : producer byte push; fifo_full reports full
//   key_wr_*            : host load port for the 16-byte key memory
//   res_rd_addr/_data   : host combinational read of the 8-byte result memory
//   result_done         : one-cycle pulse after the core writes result byte 7
module pico2_port_responder
    import pico2_port_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pico2_port_responder_if.slave core,
    input  logic                  fifo_push,
    input  logic [7:0]            fifo_push_data,
    output logic                  fifo_full,
    input  logic                  key_wr_en,
    input  logic [3:0]            key_wr_addr,
    input  logic [7:0]            key_wr_data,
    input  logic [2:0]            res_rd_addr,
    output logic [7:0]            res_rd_data,
    output logic                  result_done
);
    logic [7:0] key_mem [16];
    logic [7:0] res_mem [8];

    logic [3:0] key_addr_q, key_addr_d;
    logic [2:0] res_addr_q, res_addr_d;
    logic [7:0] pop_data_q, pop_data_d;
    logic [7:0] in_port_q, in_port_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;
    logic       result_done_q, result_done_d;

    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       wr_key_addr, wr_res_addr, wr_res_data, wr_status, pop_req;

    assign wr_key_addr = core.write_strobe && (core.port_id == PORT_KEY_ADDR);
    assign wr_res_addr = core.write_strobe && (core.port_id == PORT_RES_ADDR);
    assign wr_res_data = core.write_strobe && (core.port_id == PORT_RES_DATA);
    assign wr_status   = core.write_strobe && (core.port_id == PORT_STATUS);
    assign pop_req     = core.read_strobe  && (core.port_id == PORT_FIFO_POP);

    pico2_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (pop_req),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        key_addr_d    = key_addr_q;
        res_addr_d    = res_addr_q;
        pop_data_d    = pop_data_q;
        in_port_d     = 8'h00;

        if (wr_key_addr) key_addr_d = core.out_port[3:0];
        if (wr_res_addr) res_addr_d = core.out_port[2:0];
        if (pop_req && !fifo_empty) pop_data_d = fifo_head;

        // Sticky flags: a new event in the same cycle as a clear wins.
        underflow_d   = (pop_req && fifo_empty) || (underflow_q && !wr_status);
        overflow_d    = (fifo_push && fifo_full) || (overflow_q && !wr_status);
        result_done_d = wr_res_data && (res_addr_q == 3'd7);

        // Read mux uses pre-edge state, so a same-cycle host key write or
        // pop returns the old value here and the new one a cycle later.
        case (core.port_id)
            PORT_KEY_DATA: in_port_d = key_mem[key_addr_q];
            PORT_FIFO_POP: in_port_d = pop_data_q;
            PORT_STATUS:   in_port_d = pack_status(fifo_empty, fifo_full,
                                                   overflow_q, underflow_q);
            default:       in_port_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_addr_q    <= '0;
            res_addr_q    <= '0;
            pop_data_q    <= '0;
            in_port_q     <= '0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            result_done_q <= 1'b0;
        end else begin
            key_addr_q    <= key_addr_d;
            res_addr_q    <= res_addr_d;
            pop_data_q    <= pop_data_d;
            in_port_q     <= in_port_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            result_done_q <= result_done_d;
        end
    end

    // Memory contents survive reset.
    always_ff @(posedge clk) begin
        if (key_wr_en)   key_mem[key_wr_addr] <= key_wr_data;
        if (wr_res_data) res_mem[res_addr_q]  <= core.out_port;
    end

    assign core.in_port = in_port_q;
    assign res_rd_data  = res_mem[res_rd_addr];
    assign result_done  = result_done_q;

endmodule

// File: tb/tb_pico2_port_responder.sv
module tb_pico2_port_responder;
    import pico2_port_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       fifo_push = 1'b0;
    logic [7:0] fifo_push_data = 8'h00;
    logic       fifo_full;
    logic       key_wr_en = 1'b0;
    logic [3:0] key_wr_addr = 4'h0;
    logic [7:0] key_wr_data = 8'h00;
    logic [2:0] res_rd_addr = 3'd0;
    logic [7:0] res_rd_data;
    logic       result_done;

    pico2_port_responder_if core_if ();

    pico2_port_responder #(
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .core           (core_if),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_full      (fifo_full),
        .key_wr_en      (key_wr_en),
        .key_wr_addr    (key_wr_addr),
        .key_wr_data    (key_wr_data),
        .res_rd_addr    (res_rd_addr),
        .res_rd_data    (res_rd_data),
        .result_done    (result_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_steps  = 0;

    // Reference model: a queue of bytes plus plain state variables.
    logic [7:0] m_key [16];
    logic [7:0] m_res [8];
    bit         m_res_ok [8];
    logic [7:0] m_q [$];
    logic [3:0] m_kaddr;
    logic [2:0] m_raddr;
    logic [7:0] m_pop;
    bit         m_ovf, m_unf;

    function automatic logic [7:0] m_status();
        logic [7:0] s;
        s = 8'h00;
        s[0] = (m_q.size() == 0);
        s[1] = (m_q.size() == DEPTH);
        s[2] = m_ovf;
        s[3] = m_unf;
        return s;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_kaddr = 4'h0;
        m_raddr = 3'd0;
        m_pop   = 8'h00;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    endtask

    // One core/host transaction lasting one clock; checks against the model.
    task automatic step(input logic [7:0] pid, input logic ws, input logic rs,
                        input logic [7:0] op, input logic push, input logic [7:0] pdata,
                        input logic kwe, input logic [3:0] kwa, input logic [7:0] kwd,
                        input string tag);
        logic [7:0] exp_in;
        bit was_full, was_empty, set_ovf, set_unf, clr, exp_done;
        logic [2:0] rra;
        rra = 3'($urandom_range(0, 7));
        core_if.port_id      = pid;
        core_if.write_strobe = ws;
        core_if.read_strobe  = rs;
        core_if.out_port     = op;
        fifo_push            = push;
        fifo_push_data       = pdata;
        key_wr_en            = kwe;
        key_wr_addr          = kwa;
        key_wr_data          = kwd;
        res_rd_addr          = rra;

        if (pid == PORT_KEY_DATA)      exp_in = m_key[m_kaddr];
        else if (pid == PORT_FIFO_POP) exp_in = m_pop;
        else if (pid == PORT_STATUS)   exp_in = m_status();
        else                           exp_in = 8'h00;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);

        @(posedge clk);
        #1;

        set_ovf = 0; set_unf = 0; exp_done = 0;
        if (rs && pid == PORT_FIFO_POP) begin
            if (was_empty) set_unf = 1;
            else           m_pop = m_q.pop_front();
        end
        if (push) begin
            if (was_full) set_ovf = 1;
            else          m_q.push_back(pdata);
        end
        clr   = ws && (pid == PORT_STATUS);
        m_unf = set_unf || (m_unf && !clr);
        m_ovf = set_ovf || (m_ovf && !clr);
        if (ws && pid == PORT_KEY_ADDR) m_kaddr = op[3:0];
        if (ws && pid == PORT_RES_ADDR) m_raddr = op[2:0];
        if (ws && pid == PORT_RES_DATA) begin
            m_res[m_raddr]    = op;
            m_res_ok[m_raddr] = 1'b1;
            exp_done          = (m_raddr == 3'd7);
        end
        if (kwe) m_key[kwa] = kwd;

        n_steps++;
        $display("step %0d %s pid=%02h ws=%0d rs=%0d op=%02h push=%0d in_port=%02h full=%0d done=%0d",
                 n_steps, tag, pid, ws, rs, op, push, core_if.in_port, fifo_full, result_done);
        check({tag, ":in_port"}, core_if.in_port, exp_in);
        check({tag, ":fifo_full"}, {7'b0, fifo_full}, {7'b0, (m_q.size() == DEPTH)});
        check({tag, ":result_done"}, {7'b0, result_done}, {7'b0, exp_done});
        if (m_res_ok[rra]) check({tag, ":res_rd_data"}, res_rd_data, m_res[rra]);
    endtask

    task automatic cwr(input logic [7:0] pid, input logic [7:0] d, input string tag);
        step(pid, 1'b1, 1'b0, d, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, tag);
    endtask

    task automatic crd(input logic [7:0] pid, input logic rs, input string tag);
        step(pid, 1'b0, rs, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 8'h00, tag);
    endtask

    task automatic cpush(input logic [7:0] d, input string tag);
        step(8'h00, 1'b0, 1'b0, 8'h00, 1'b1, d, 1'b0, 4'h0, 8'h00, tag);
    endtask

    initial begin
        int pulses;
        int push_pct;
        logic [7:0] pid;
        core_if.port_id      = 8'h00;
        core_if.write_strobe = 1'b0;
        core_if.read_strobe  = 1'b0;
        core_if.out_port     = 8'h00;
        for (int i = 0; i < 8; i++) m_res_ok[i] = 1'b0;
        model_reset();

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset:in_port", core_if.in_port, 8'h00);
        check("reset:fifo_full", {7'b0, fifo_full}, 8'h00);
        check("reset:result_done", {7'b0, result_done}, 8'h00);
        rst_n = 1'b1;

        // Host loads key bytes; core fills result bytes 0..6
        for (int i = 0; i < 16; i++)
            step(8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 4'(i), 8'hA0 + 8'(i), "keyload");
        for (int i = 0; i < 7; i++) begin
            cwr(PORT_RES_ADDR, 8'(i), "resaddr");
            cwr(PORT_RES_DATA, 8'h30 + 8'(i), "resdata");
        end

        // Key readback
        cwr(PORT_KEY_ADDR, 8'h05, "keyaddr");
        crd(PORT_KEY_DATA, 1'b1, "keyread");
        check("key5", core_if.in_port, 8'hA5);

        // Status and single-byte pop
        crd(PORT_STATUS, 1'b1, "stat_empty");
        check("stat_empty", core_if.in_port, 8'h01);
        cpush(8'h3C, "push3c");
        crd(PORT_STATUS, 1'b1, "stat_one");
        check("stat_one", core_if.in_port, 8'h00);
        crd(PORT_FIFO_POP, 1'b1, "pop3c");
        crd(PORT_FIFO_POP, 1'b0, "pop3c_hold");
        check("pop3c", core_if.in_port, 8'h3C);

        // Pop while empty
        crd(PORT_FIFO_POP, 1'b1, "pop_empty");
        crd(PORT_STATUS, 1'b1, "stat_unf");
        check("stat_unf", core_if.in_port, 8'h09);
        crd(PORT_FIFO_POP, 1'b0, "popdata_kept");
        check("popdata_kept", core_if.in_port, 8'h3C);
        cwr(PORT_STATUS, 8'h00, "clear");
        crd(PORT_STATUS, 1'b1, "stat_cleared");
        check("stat_cleared", core_if.in_port, 8'h01);

        // Overfill, clear, drain in order
        for (int i = 0; i < 17; i++) cpush(8'h10 + 8'(i), "fill");
        check("fill_full", {7'b0, fifo_full}, 8'h01);
        crd(PORT_STATUS, 1'b1, "stat_ovf");
        check("stat_ovf", core_if.in_port, 8'h06);
        cwr(PORT_STATUS, 8'h00, "clear_ovf");
        crd(PORT_STATUS, 1'b1, "stat_full");
        check("stat_full", core_if.in_port, 8'h02);
        for (int i = 0; i <= 16; i++) begin
            crd(PORT_FIFO_POP, (i < 16), "drain");
            if (i > 0) check("drain_order", core_if.in_port, 8'h10 + 8'(i - 1));
        end
        crd(PORT_STATUS, 1'b1, "stat_drained");
        check("stat_drained", core_if.in_port, 8'h01);

        // Result byte 7 and done pulse
        pulses = 0;
        cwr(PORT_RES_ADDR, 8'h07, "res7addr");
        pulses += int'(result_done);
        cwr(PORT_RES_DATA, 8'h5A, "res7data");
        pulses += int'(result_done);
        check("done_now", {7'b0, result_done}, 8'h01);
        res_rd_addr = 3'd7;
        #1;
        check("res7", res_rd_data, 8'h5A);
        for (int i = 0; i < 2; i++) begin
            crd(8'h00, 1'b0, "res7_idle");
            pulses += int'(result_done);
        end
        check("done_pulses", 8'(pulses), 8'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 240; i++) begin
            push_pct = (i < 120) ? 60 : 15;
            case ($urandom_range(0, 7))
                0: pid = PORT_KEY_ADDR;
                1: pid = PORT_KEY_DATA;
                2, 3: pid = PORT_FIFO_POP;
                4: pid = PORT_STATUS;
                5: pid = PORT_RES_ADDR;
                6: pid = PORT_RES_DATA;
                default: pid = 8'($urandom);
            endcase
            if ($urandom_range(0, 2) == 0)
                step(pid, 1'b1, 1'b0, 8'($urandom), ($urandom_range(0, 99) < push_pct),
                     8'($urandom), ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom), "rand");
            else
                step(pid, 1'b0, ($urandom_range(0, 1) == 1), 8'($urandom),
                     ($urandom_range(0, 99) < push_pct), 8'($urandom),
                     ($urandom_range(0, 3) == 0), 4'($urandom), 8'($urandom), "rand");
        end

        // Reset in the middle of a pop
        cwr(PORT_STATUS, 8'h00, "pre_rst_clear");
        for (int i = 0; i < 3; i++) cpush(8'hC0 + 8'(i), "pre_rst_push");
        core_if.port_id      = PORT_FIFO_POP;
        core_if.write_strobe = 1'b0;
        core_if.read_strobe  = 1'b1;
        fifo_push            = 1'b0;
        key_wr_en            = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst:in_port", core_if.in_port, 8'h00);
        check("midrst:fifo_full", {7'b0, fifo_full}, 8'h00);
        check("midrst:result_done", {7'b0, result_done}, 8'h00);
        @(posedge clk);
        #1;
        core_if.read_strobe = 1'b0;
        core_if.port_id     = 8'h00;
        rst_n = 1'b1;
        model_reset();
        crd(PORT_STATUS, 1'b1, "post_rst_stat");
        check("post_rst_stat", core_if.in_port, 8'h01);
        crd(PORT_FIFO_POP, 1'b0, "post_rst_popdata");
        check("post_rst_popdata", core_if.in_port, 8'h00);
        cpush(8'hAA, "post_rst_push");
        cpush(8'hBB, "post_rst_push");
        crd(PORT_FIFO_POP, 1'b1, "post_rst_pop");
        crd(PORT_FIFO_POP, 1'b0, "post_rst_hold");
        check("post_rst_first", core_if.in_port, 8'hAA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
